decim_avg_fifo: RTL and testbench

Downstream stage of the FIR filter. It consumes the filter's signed output stream and decimates it by M = 2^LOG2_M using block averaging (accumulate-and-dump with rounding). Decimated samples are buffered in a small FIFO and presented on a valid/ready interface to the next consumer. Overflow is flagged with a sticky bit.

---
 rtl/decim_avg_fifo.sv | 134 +++++++++++++
 tb/tb_decim_avg_fifo.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/decim_avg_fifo.sv
// decim_avg_fifo: block-average decimator (M = 2^LOG2_M) for the FIR output
// stream, with a small output FIFO on a valid/ready port and sticky overflow.
module decim_avg_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int LOG2_M     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              in_valid,
   input  logic signed [DATA_WIDTH-1:0]      in_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic signed [DATA_WIDTH-1:0]      out_data,
   output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
   output logic                              overflow,
   input  logic                              clear_ovf
);

   localparam int AW = DATA_WIDTH + LOG2_M;
   localparam int PW = (LOG2_M > 0) ? LOG2_M : 1;
   localparam int FW = $clog2(FIFO_DEPTH);
   localparam int CW = FW + 1;
   localparam logic [PW-1:0] PH_LAST = PW'((1 << LOG2_M) - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   logic signed [AW-1:0]         acc;
   logic signed [AW-1:0]         sum;
   logic [PW-1:0]                ph;
   logic                         last;
   logic signed [DATA_WIDTH-1:0] result;

   logic [DATA_WIDTH-1:0]        mem [FIFO_DEPTH];
   logic [FW-1:0]                wr_ptr;
   logic [FW-1:0]                rd_ptr;
   logic [CW-1:0]                count;

   logic                         push_req;
   logic                         pop;
   logic                         full;
   logic                         do_push;
   logic                         drop;

   // Block sum including the current sample; the full M-sample sum fits AW
   assign sum  = acc + AW'(in_data);
   assign last = (ph == PH_LAST);

   generate
      if (LOG2_M > 0) begin : g_avg
         logic signed [AW-1:0] rnd_sum;
         logic                 unused_frac;
         // Round half up; M*max + M/2 still stays below 2^(AW-1)
         assign rnd_sum     = sum + AW'(2 ** (LOG2_M - 1));
         assign result      = rnd_sum[AW-1:LOG2_M];
         assign unused_frac = ^rnd_sum[LOG2_M-1:0];
      end else begin : g_pass
         assign result = in_data;
      end
   endgenerate

   // Accumulate-and-dump: clear on the M-th sample, hold while idle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc <= '0;
         ph  <= '0;
      end else if (in_valid) begin
         if (last) begin
            acc <= '0;
            ph  <= '0;
         end else begin
            acc <= sum;
            ph  <= ph + PW'(1);
         end
      end
   end

   assign push_req = in_valid && last;
   assign out_valid = (count != '0);
   assign pop      = out_valid && out_ready;
   assign full     = (count == FULL_CNT);
   // A pop in the same cycle frees the slot the push needs
   assign do_push  = push_req && (!full || pop);
   assign drop     = push_req && full && !pop;

   // FIFO storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= result;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + FW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + FW'(1);
         end
         unique case (1'b1)
            (do_push && !pop): count <= count + CW'(1);
            (pop && !do_push): count <= count - CW'(1);
            default:           count <= count;
         endcase
      end
   end

   // Sticky overflow: a dropped result wins over a clear request
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clear_ovf) begin
         overflow <= 1'b0;
      end
   end

   // Head of FIFO, forced to zero when empty
   always_comb begin
      out_data = '0;
      if (out_valid) begin
         out_data = mem[rd_ptr];
      end
   end

   assign fifo_count = count;

endmodule

// File: tb/tb_decim_avg_fifo.sv
// tb_decim_avg_fifo: directed checks of averaging, rounding, gaps,
// back-pressure, overflow, simultaneous push/pop and reset.
module tb_decim_avg_fifo;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               in_valid;
   logic signed [15:0] in_data;
   logic               out_valid;
   logic               out_ready;
   logic signed [15:0] out_data;
   logic [2:0]         fifo_count;
   logic               overflow;
   logic               clear_ovf;

   int vectors = 0;
   int errors  = 0;

   decim_avg_fifo #(
      .DATA_WIDTH(16),
      .LOG2_M(2),
      .FIFO_DEPTH(4)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .in_valid(in_valid),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .fifo_count(fifo_count),
      .overflow(overflow),
      .clear_ovf(clear_ovf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic feed4(input logic signed [15:0] a, input logic signed [15:0] b,
                        input logic signed [15:0] c, input logic signed [15:0] d);
      in_valid = 1'b1;
      in_data = a; tick();
      in_data = b; tick();
      in_data = c; tick();
      in_data = d; tick();
      in_valid = 1'b0;
      in_data = '0;
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      clear_ovf = 1'b0;
      tick();
      tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_ovf", overflow, 0);
      reset_n = 1'b1;
      tick();

      // 1,2,3,4 -> (10+2)>>>2 = 3, visible right after the 4th sample
      in_valid = 1'b1;
      in_data = 16'sd1; tick();
      in_data = 16'sd2; tick();
      in_data = 16'sd3; tick();
      chk("lat_not_yet", out_valid, 0);
      in_data = 16'sd4; tick();
      in_valid = 1'b0;
      chk("avg_pos_valid", out_valid, 1);
      chk("avg_pos_data", out_data, 3);
      chk("avg_pos_count", fifo_count, 1);
      tick();
      chk("hold_data", out_data, 3);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      chk("pop_empty", out_valid, 0);
      chk("empty_data0", out_data, 0);

      // -1..-4 -> (-10+2)>>>2 = -2
      feed4(-16'sd1, -16'sd2, -16'sd3, -16'sd4);
      chk("avg_neg_data", out_data, -2);
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      feed4(16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767);
      chk("max_data", out_data, 32767);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      feed4(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768);
      chk("min_data", out_data, -32768);
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      // Gapped input: phase holds across idle cycles
      for (int s = 0; s < 4; s++) begin
         in_valid = 1'b1; in_data = 16'sd8; tick();
         in_valid = 1'b0; in_data = '0;
         if (s < 3) begin
            tick(); tick(); tick();
            chk($sformatf("gap_idle%0d", s), out_valid, 0);
         end
      end
      chk("gap_valid", out_valid, 1);
      chk("gap_data", out_data, 8);
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      // Back-pressure: fifth block is dropped
      for (int v = 10; v <= 40; v += 10) begin
         feed4(16'(v), 16'(v), 16'(v), 16'(v));
      end
      chk("bp_count4", fifo_count, 4);
      chk("bp_ovf_pre", overflow, 0);
      feed4(16'sd50, 16'sd50, 16'sd50, 16'sd50);
      chk("bp_count_full", fifo_count, 4);
      chk("bp_ovf_set", overflow, 1);
      out_ready = 1'b1;
      for (int v = 10; v <= 40; v += 10) begin
         chk($sformatf("drain_%0d", v), out_data, v);
         tick();
      end
      out_ready = 1'b0;
      chk("drain_valid0", out_valid, 0);
      chk("drain_count0", fifo_count, 0);
      chk("ovf_sticky", overflow, 1);
      clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
      chk("ovf_clear", overflow, 0);

      // Full FIFO with pop on the cycle a new result lands
      for (int v = 60; v <= 63; v++) begin
         feed4(16'(v), 16'(v), 16'(v), 16'(v));
      end
      in_valid = 1'b1; in_data = 16'sd64;
      tick(); tick(); tick();
      out_ready = 1'b1; tick();
      in_valid = 1'b0; out_ready = 1'b0;
      chk("pp_count", fifo_count, 4);
      chk("pp_ovf", overflow, 0);
      out_ready = 1'b1;
      for (int v = 61; v <= 64; v++) begin
         chk($sformatf("pp_drain_%0d", v), out_data, v);
         tick();
      end
      out_ready = 1'b0;
      chk("pp_empty", out_valid, 0);

      // Reset mid-block with a non-empty FIFO
      feed4(16'sd7, 16'sd7, 16'sd7, 16'sd7);
      in_valid = 1'b1; in_data = 16'sd100; tick(); tick();
      in_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_data", out_data, 0);
      chk("mid_rst_count", fifo_count, 0);
      tick();
      reset_n = 1'b1;
      tick();
      feed4(16'sd4, 16'sd4, 16'sd4, 16'sd4);
      chk("post_rst_data", out_data, 4);
      chk("post_rst_count", fifo_count, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
